// File: rtl/l1d_cache_pkg.sv
// Shared definitions for the L1 data cache.
//   DATA_SOURCE_* : data-source codes returned by the memory controller
//   PERIPH_BIT    : address bit that selects the peripheral space
//   is_cacheable  : true for addresses outside the peripheral space
package l1d_cache_pkg;

    localparam logic [1:0] DATA_SOURCE_NONE = 2'd0;
    localparam logic [1:0] DATA_SOURCE_ROM  = 2'd1;
    localparam logic [1:0] DATA_SOURCE_RAM  = 2'd2;
    localparam logic [1:0] DATA_SOURCE_PER  = 2'd3;

    localparam int PERIPH_BIT = 8;

    function automatic logic is_cacheable(input logic [31:0] addr);
        return ~addr[PERIPH_BIT];
    endfunction

endpackage

// File: rtl/l1d_cache_array.sv
// Storage for the direct-mapped L1D: valid bits, tags and one data word per line.
//   clock, reset_n              : clock, async active-low reset (clears valid bits only)
//   rd_index -> rd_valid/tag/data : combinational read port
//   wr_en, wr_index, wr_tag, wr_data : single write port, also marks the line valid
//   flash_clear                 : clears every valid bit on the next edge
module l1d_cache_array #(
    parameter int LINES    = 8,
    parameter int IDX_BITS = $clog2(LINES),
    parameter int TAG_BITS = 30 - IDX_BITS
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [IDX_BITS-1:0] rd_index,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_data,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_data,
    input  logic                flash_clear
);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    // Flash clear is written last so it overrides a fill in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else begin
            if (wr_en)
                valid[wr_index] <= 1'b1;
            if (flash_clear)
                valid <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
//   clock, reset_n                   : clock, async active-low reset
//   cpu_address/write_data/read/write : CPU load/store request (held while stalled)
//   invalidate                       : clear all valid bits (deferred while busy)
//   cpu_read_data, cpu_stall         : load result and hold request to the CPU
//   mem_address/write_data/read/write : request to the memory controller L1D port
//   mem_data, mem_data_source, mem_stall : controller response and stall
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accept requests; read hits complete here with zero latency
// REQ    | mem_read issued for req_addr, held while mem_stall
// RESP   | sample returned data, fill line if cacheable RAM data
// WR     | mem_write issued for req_addr/req_data, held while mem_stall
// DONE   | release the CPU; loads return resp_data
module l1d_cache
    import l1d_cache_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic        invalidate,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data,
    input  logic [1:0]  mem_data_source,
    input  logic        mem_stall
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = 30 - IDX_BITS;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] resp_data;
    logic        inv_pending;

    logic [IDX_BITS-1:0] cpu_index;
    logic [TAG_BITS-1:0] cpu_tag;
    logic [IDX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0] req_tag;

    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]         rd_data;
    logic                hit;
    logic                fill;
    logic                write_hit;
    logic                flash;
    logic                arr_wr_en;
    logic [IDX_BITS-1:0] arr_wr_index;
    logic [TAG_BITS-1:0] arr_wr_tag;
    logic [31:0]         arr_wr_data;

    assign cpu_index = cpu_address[2 +: IDX_BITS];
    assign cpu_tag   = cpu_address[31 -: TAG_BITS];
    assign req_index = req_addr[2 +: IDX_BITS];
    assign req_tag   = req_addr[31 -: TAG_BITS];

    assign hit       = is_cacheable(cpu_address) && rd_valid && (rd_tag == cpu_tag);
    assign fill      = (state == S_RESP) && is_cacheable(req_addr)
                       && (mem_data_source == DATA_SOURCE_RAM);
    assign write_hit = (state == S_IDLE) && cpu_write && hit;
    assign flash     = (state == S_IDLE) && (invalidate || inv_pending);

    // Fill and store-hit never coincide: one needs RESP, the other IDLE.
    assign arr_wr_en    = fill || write_hit;
    assign arr_wr_index = fill ? req_index : cpu_index;
    assign arr_wr_tag   = fill ? req_tag   : cpu_tag;
    assign arr_wr_data  = fill ? mem_data  : cpu_write_data;

    l1d_cache_array #(
        .LINES    (LINES),
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_index    (cpu_index),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_en       (arr_wr_en),
        .wr_index    (arr_wr_index),
        .wr_tag      (arr_wr_tag),
        .wr_data     (arr_wr_data),
        .flash_clear (flash)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            req_addr    <= '0;
            req_data    <= '0;
            resp_data   <= '0;
            inv_pending <= 1'b0;
        end else begin
            // An invalidate seen while busy is held until the next IDLE cycle,
            // which is always after any fill of the current transaction.
            if (state == S_IDLE)
                inv_pending <= 1'b0;
            else if (invalidate)
                inv_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cpu_write) begin
                        req_addr <= cpu_address;
                        req_data <= cpu_write_data;
                        state    <= S_WR;
                    end else if (cpu_read && !hit) begin
                        req_addr <= cpu_address;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!mem_stall)
                        state <= S_RESP;
                end
                S_RESP: begin
                    resp_data <= mem_data;
                    state     <= S_DONE;
                end
                S_WR: begin
                    if (!mem_stall)
                        state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs depend only on state flops and latched request
    // registers, so they never see CPU-side combinational paths.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            S_REQ: begin
                mem_read    = 1'b1;
                mem_address = req_addr;
            end
            S_WR: begin
                mem_write      = 1'b1;
                mem_address    = req_addr;
                mem_write_data = req_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        cpu_stall     = 1'b0;
        cpu_read_data = '0;
        case (state)
            S_IDLE: begin
                if (cpu_write) begin
                    cpu_stall = 1'b1;
                end else if (cpu_read) begin
                    if (hit)
                        cpu_read_data = rd_data;
                    else
                        cpu_stall = 1'b1;
                end
            end
            S_REQ, S_RESP, S_WR: begin
                cpu_stall = 1'b1;
            end
            S_DONE: begin
                if (cpu_read && !cpu_write)
                    cpu_read_data = resp_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1d_cache.sv
module tb_l1d_cache;
    import l1d_cache_pkg::*;

    localparam int LINES = 8;
    localparam int IDX   = 3;

    logic        clock;
    logic        reset_n;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic        cpu_read;
    logic        cpu_write;
    logic        invalidate;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;
    logic [1:0]  mem_data_source;
    logic        mem_stall;

    l1d_cache #(.LINES(LINES)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cpu_address     (cpu_address),
        .cpu_write_data  (cpu_write_data),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .invalidate      (invalidate),
        .cpu_read_data   (cpu_read_data),
        .cpu_stall       (cpu_stall),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_data        (mem_data),
        .mem_data_source (mem_data_source),
        .mem_stall       (mem_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: what the cache should hold and what memory contains.
    bit   [LINES-1:0] ref_valid;
    logic [31:0]      ref_tag  [LINES];
    logic [31:0]      ref_data [LINES];
    logic [31:0]      mem_model [logic [31:0]];

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a >> 2) & (LINES - 1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (2 + IDX);
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_model.exists(a))
            return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return (a[8] == 1'b0) && ref_valid[idx_of(a)] && (ref_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic idle_check(input string name);
        chk({name, ".idle_stall"}, {31'b0, cpu_stall}, 32'd0);
        chk({name, ".idle_rdata"}, cpu_read_data, 32'd0);
        chk({name, ".idle_mrd"},   {31'b0, mem_read}, 32'd0);
        chk({name, ".idle_mwr"},   {31'b0, mem_write}, 32'd0);
        chk({name, ".idle_maddr"}, mem_address, 32'd0);
        chk({name, ".idle_mwdata"}, mem_write_data, 32'd0);
    endtask

    // One CPU transaction, entered and left at posedge+1 with the DUT idle.
    // k = number of cycles the controller stalls the memory request.
    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] src, input int k, input bit inv_mid,
                         input string name);
        bit          exp_hit;
        logic [31:0] mv;
        logic [31:0] exp_data;
        int          rel;
        int          n_rd;
        int          n_wr;
        int          exp_rel;
        int          n;
        exp_hit  = model_hit(addr);
        mv       = mem_val(addr);
        exp_data = exp_hit ? ref_data[idx_of(addr)] : mv;
        exp_rel  = wr ? 2 + k : (exp_hit ? 0 : 3 + k);

        cpu_address     = addr;
        cpu_write_data  = wdata;
        cpu_read        = !wr;
        cpu_write       = wr;
        mem_data        = mv;
        mem_data_source = src;
        mem_stall       = 1'b0;
        rel  = -1;
        n_rd = 0;
        n_wr = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            if (inv_mid)
                invalidate = (c == 1);
            chk({name, ".excl"}, {31'b0, mem_read & mem_write}, 32'd0);
            if (mem_read) begin
                n_rd++;
                chk({name, ".rd_addr"}, mem_address, addr);
            end
            if (mem_write) begin
                n_wr++;
                chk({name, ".wr_addr"}, mem_address, addr);
                chk({name, ".wr_data"}, mem_write_data, wdata);
            end
            n = mem_read ? n_rd : n_wr;
            mem_stall = (mem_read || mem_write) ? (n <= k) : 1'b0;
            if (!cpu_stall) begin
                rel = c;
                if (!wr)
                    chk({name, ".rdata"}, cpu_read_data, exp_data);
                break;
            end
        end
        if (rel < 0)
            $display("FAIL %s.timeout: got no release expected release at cycle %0d", name, exp_rel);
        chk({name, ".latency"}, rel, exp_rel);
        chk({name, ".n_mem_rd"}, n_rd, (wr || exp_hit) ? 0 : k + 1);
        chk({name, ".n_mem_wr"}, n_wr, wr ? k + 1 : 0);

        if (wr) begin
            mem_model[addr] = wdata;
            if (exp_hit)
                ref_data[idx_of(addr)] = wdata;
        end else if (!exp_hit && addr[8] == 1'b0 && src == DATA_SOURCE_RAM) begin
            ref_valid[idx_of(addr)] = 1'b1;
            ref_tag[idx_of(addr)]   = tag_of(addr);
            ref_data[idx_of(addr)]  = mv;
        end
        if (inv_mid)
            ref_valid = '0;

        @(posedge clock);
        #1;
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        mem_stall  = 1'b0;
        invalidate = 1'b0;
        @(negedge clock);
        idle_check(name);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        bit          w;
        bit          seen;

        reset_n         = 1'b0;
        cpu_address     = '0;
        cpu_write_data  = '0;
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        invalidate      = 1'b0;
        mem_data        = '0;
        mem_data_source = DATA_SOURCE_NONE;
        mem_stall       = 1'b0;
        ref_valid       = '0;
        mem_model[32'h80]  = 32'hDEAD_BEEF;
        mem_model[32'h104] = 32'h0000_0005;

        #12;
        idle_check("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Cold miss, then hit, store hit, hit on stored value.
        do_op(1'b0, 32'h80, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "cold_rd");
        do_op(1'b0, 32'h80, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "hit_rd");
        do_op(1'b1, 32'h80, 32'h1234_5678, DATA_SOURCE_RAM, 0, 1'b0, "wr_hit");
        do_op(1'b0, 32'h80, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "hit_after_wr");

        // Peripheral reads are never cached.
        do_op(1'b0, 32'h104, 32'h0, DATA_SOURCE_PER, 0, 1'b0, "per_rd1");
        do_op(1'b0, 32'h104, 32'h0, DATA_SOURCE_PER, 0, 1'b0, "per_rd2");

        // Miss under three stall cycles (evicts 0x80 from line 0).
        do_op(1'b0, 32'h200, 32'h0, DATA_SOURCE_RAM, 3, 1'b0, "stall_rd");
        do_op(1'b1, 32'h208, 32'hCAFE_0001, DATA_SOURCE_RAM, 2, 1'b0, "stall_wr_miss");

        // Reset in RESP of a miss to 0x40: outputs drop at once, no fill.
        cpu_address     = 32'h40;
        cpu_read        = 1'b1;
        mem_data        = mem_val(32'h40);
        mem_data_source = DATA_SOURCE_RAM;
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clock);
            seen = mem_read;
        end
        chk("rst_resp.saw_req", {31'b0, seen}, 32'd1);
        @(negedge clock);
        reset_n  = 1'b0;
        cpu_read = 1'b0;
        #1;
        idle_check("rst_resp");
        ref_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        do_op(1'b0, 32'h40, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "after_rst_rd");

        // Idle invalidate after filling 0x80.
        do_op(1'b0, 32'h80, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "fill80");
        do_op(1'b0, 32'h80, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "hit80");
        invalidate = 1'b1;
        @(posedge clock);
        #1;
        invalidate = 1'b0;
        ref_valid  = '0;
        do_op(1'b0, 32'h80, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "inv_rd");

        // Invalidate raised while a fill is in flight applies after the fill.
        do_op(1'b0, 32'h84, 32'h0, DATA_SOURCE_RAM, 1, 1'b1, "inv_busy");
        do_op(1'b0, 32'h84, 32'h0, DATA_SOURCE_RAM, 0, 1'b0, "inv_busy_rd");

        // ROM data is not filled.
        do_op(1'b0, 32'h8C, 32'h0, DATA_SOURCE_ROM, 0, 1'b0, "rom_rd1");
        do_op(1'b0, 32'h8C, 32'h0, DATA_SOURCE_ROM, 0, 1'b0, "rom_rd2");

        // Random traffic over a small address window to force conflicts.
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 127) << 2);
            w = ($urandom_range(0, 9) < 3);
            if (a[8])
                s = DATA_SOURCE_PER;
            else
                s = ($urandom_range(0, 9) < 2) ? DATA_SOURCE_ROM : DATA_SOURCE_RAM;
            do_op(w, a, $urandom, s, $urandom_range(0, 2),
                  (w || !model_hit(a)) && ($urandom_range(0, 19) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l1d_cache.md
Name: l1d_cache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache between the CPU load/store stage and the memory controller's L1D port.
- Acts as the initiator on that port: issues read and write requests, honours the controller's stall, and consumes the returned data and data source.
- Peripheral addresses (address bit 8 set) and any non-RAM source bypass the array and are never cached.

Parameters:
- LINES, 8, number of one-word lines; must be a power of two ≥ 2.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cpu_address  in  32  byte address; bits [1:0] ignored
- cpu_write_data  in  32  store data
- cpu_read  in  1  load request, held until cpu_stall is low
- cpu_write  in  1  store request, held until cpu_stall is low; wins if asserted together with cpu_read
- invalidate  in  1  request to clear all valid bits
- cpu_read_data  out  32  load result, valid when cpu_read=1 and cpu_stall=0
- cpu_stall  out  1  CPU must hold its request
- mem_address  out  32  to controller l1d_address
- mem_write_data  out  32  to controller l1d_input_data
- mem_read  out  1  to controller l1d_mem_read
- mem_write  out  1  to controller l1d_mem_write
- mem_data  in  32  controller output_data
- mem_data_source  in  2  controller data_source (shared DATA_SOURCE_* codes)
- mem_stall  in  1  controller stall_l1d

Behaviour:
- Index = cpu_address[2 +: IDX_BITS], with IDX_BITS = $clog2(LINES). Tag = cpu_address[31 : 2+IDX_BITS].
- Arrays: valid[LINES], tag[LINES], data[LINES].
- Cacheable means cpu_address[8] = 0.
- Hit means cacheable, line valid, and tag match.
- FSM states: IDLE, REQ, RESP, WR, DONE.
  - IDLE, read hit: cpu_stall=0 combinationally; cpu_read_data = data[index]. Zero-latency hit.
  - IDLE, read miss or uncacheable read: cpu_stall=1; go to REQ. Latch address into req_addr.
  - IDLE, write: cpu_stall=1. If hit, update data[index] with cpu_write_data. Latch address and data; go to WR.
  - REQ: mem_read=1, mem_address=req_addr. Stay while mem_stall=1; otherwise go to RESP.
  - RESP: sample mem_data into resp_data. If req_addr is cacheable and mem_data_source == DATA_SOURCE_RAM, fill the line: valid=1, tag, data. Go to DONE.
  - WR: mem_write=1, mem_address and mem_write_data from the latched values. Stay while mem_stall=1; otherwise go to DONE.
  - DONE: cpu_stall=0; cpu_read_data = resp_data for reads. Go to IDLE.
  - cpu_stall=1 in REQ, RESP and WR.
- Latency with mem_stall=0:
  - Read miss: stall in cycles 0–2, data released in cycle 3.
  - Write: stall in cycles 0–1, released in cycle 2.
  - Each cycle of mem_stall adds one cycle.
- Outputs:
  - mem_read and mem_write are never high together.
  - Both are 0 outside REQ and WR.
  - mem_address and mem_write_data are 0 when idle.
- Invalidate:
  - In IDLE with no request in progress, clears all valid bits on the next edge.
  - If asserted while busy, it is latched as pending and applied on the first IDLE cycle.
  - When invalidate and a fill occur in the same cycle, invalidate applies after the fill.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; all valid bits, resp_data, pending-invalidate, req_addr and req_data clear to 0.
  - All mem_* outputs are 0. cpu_stall and cpu_read_data are 0 with no request.
  - A refill in flight is aborted with no line written.
  - Tag and data arrays need no reset.
- No request in IDLE: cpu_stall=0, cpu_read_data=0.

Decomposition:
- Shared defines file holds DATA_SOURCE_NONE/ROM/RAM/PER and the peripheral-select bit position (8); this block uses them and the memory controller already does.
- FSM state encodings stay local localparams.
- One natural sub-module, l1d_cache_array: valid/tag/data storage with a combinational read port, one write port, and a flash-invalidate input.

Test Plan:
- Cold read of 0x80 (LINES=8), controller returns 0xDEADBEEF with source RAM, mem_stall=0 → mem_read high cycle 1 with mem_address=0x80; cpu_stall low cycle 3 with cpu_read_data=0xDEADBEEF.
- Repeat read of 0x80 → cpu_stall=0 in cycle 0, data 0xDEADBEEF, mem_read stays 0.
- Write 0x12345678 to 0x80 (hit), then read 0x80 → mem_write one cycle with data 0x12345678; following read hits with 0x12345678.
- Read of 0x104 (peripheral), source PER, data 0x5 → returns 0x5; a second read of 0x104 misses again and reissues mem_read.
- Read miss with mem_stall=1 for 3 cycles → mem_read held 4 cycles with a constant address; cpu_stall released exactly one cycle after RESP.
- Reset asserted during RESP of a miss to 0x40, then read 0x40 → outputs 0 immediately on reset; after reset the read misses (line not filled). Separately, invalidate after filling 0x80 causes the next read of 0x80 to miss.
